// File: rtl/encoder_output_streamer_if.sv
// Word-stream bus between encoder_output_streamer (master) and its consumer (slave).
// out_parity is present only when STREAMER_PARITY_EN is defined.
interface encoder_output_streamer_if #(
  parameter int unsigned WORD_WIDTH = 64,
  parameter int unsigned IDX_BITS   = 5
);
  logic                  out_valid;
  logic                  out_ready;
  logic [WORD_WIDTH-1:0] out_data;
  logic [IDX_BITS-1:0]   out_index;
  logic                  out_last;
`ifdef STREAMER_PARITY_EN
  logic                  out_parity;
`endif

  modport master (
    output out_valid, out_data, out_index, out_last,
`ifdef STREAMER_PARITY_EN
    output out_parity,
`endif
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_index, out_last,
`ifdef STREAMER_PARITY_EN
    input  out_parity,
`endif
    output out_ready
  );
endinterface

// File: rtl/encoder_output_streamer.sv
// Captures the encoder state on a rising enc_done and streams it out word 0 first.
// Optional STREAMER_PARITY_EN adds out_parity (even parity of the current word).
`ifndef NUM_CELLS
`define NUM_CELLS 1600
`endif

module encoder_output_streamer #(
  parameter int unsigned STATE_WIDTH = `NUM_CELLS,
  parameter int unsigned WORD_WIDTH  = 64,
  parameter int unsigned NUM_WORDS   = STATE_WIDTH / WORD_WIDTH,
  parameter int unsigned IDX_BITS    = $clog2(NUM_WORDS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enc_done,
  input  logic [STATE_WIDTH-1:0] enc_data,
  encoder_output_streamer_if.master out_if,
  output logic                   busy,
  output logic                   overrun
);

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_WORDS - 1);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t                 state_q, state_d;
  logic                   done_q;
  logic [STATE_WIDTH-1:0] buffer;
  logic [IDX_BITS-1:0]    index_q;
  logic                   capture;
  logic                   handshake;
  logic                   at_last;

  assign capture   = enc_done & ~done_q;
  assign handshake = out_if.out_valid & out_if.out_ready;
  assign at_last   = (index_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (capture) state_d = STREAM;
      STREAM: if (handshake && at_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      buffer  <= '0;
      index_q <= '0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= enc_done;
      if (state_q == IDLE && capture) begin
        buffer  <= enc_data;
        index_q <= '0;
      end else if (handshake) begin
        // Shifting drains the buffer to zero, so out_data reads 0 once idle again.
        buffer  <= buffer >> WORD_WIDTH;
        index_q <= at_last ? '0 : index_q + 1'b1;
      end
      if (state_q == STREAM && capture) overrun <= 1'b1;
    end
  end

  assign busy             = (state_q != IDLE);
  assign out_if.out_valid = (state_q == STREAM);
  assign out_if.out_data  = buffer[WORD_WIDTH-1:0];
  assign out_if.out_index = index_q;
  assign out_if.out_last  = at_last & out_if.out_valid;
`ifdef STREAMER_PARITY_EN
  assign out_if.out_parity = out_if.out_valid & (^out_if.out_data);
`endif

endmodule

// File: tb/tb_encoder_output_streamer.sv
// Randomized bench for encoder_output_streamer against a queue-based reference model.
module tb_encoder_output_streamer;
  localparam int unsigned SW = 1600;
  localparam int unsigned WW = 64;
  localparam int unsigned NW = SW / WW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enc_done = 1'b0;
  logic [SW-1:0] enc_data = '0;
  logic          busy, overrun;

  encoder_output_streamer_if #(.WORD_WIDTH(WW), .IDX_BITS(5)) sif ();

  encoder_output_streamer #(.STATE_WIDTH(SW), .WORD_WIDTH(WW)) dut (
    .clk      (clk),
    .rst      (rst),
    .enc_done (enc_done),
    .enc_data (enc_data),
    .out_if   (sif.master),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model: words still owed to the consumer, front = word on the bus.
  logic [WW-1:0] exp_q[$];
  bit            m_done_q = 0;
  bit            m_overrun = 0;
  bit            m_reset_seen = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit owed;
    bit cap;
    @(posedge clk);
    m_reset_seen = !rst;
    if (!rst) begin
      exp_q.delete();
      m_overrun = 0;
      m_done_q  = 0;
    end else begin
      owed = (exp_q.size() != 0);
      cap  = enc_done && !m_done_q;
      if (owed && sif.out_ready) void'(exp_q.pop_front());
      if (cap) begin
        if (owed) m_overrun = 1;
        else for (int k = 0; k < NW; k++) exp_q.push_back(enc_data[k*WW +: WW]);
      end
      m_done_q = enc_done;
    end
    #1;
    check("out_valid", 64'(sif.out_valid), 64'(exp_q.size() != 0));
    check("busy", 64'(busy), 64'(exp_q.size() != 0));
    check("overrun", 64'(overrun), 64'(m_overrun));
    if (exp_q.size() != 0) begin
      check("out_data", sif.out_data, exp_q[0]);
      check("out_index", 64'(sif.out_index), 64'(NW - exp_q.size()));
      check("out_last", 64'(sif.out_last), 64'(exp_q.size() == 1));
`ifdef STREAMER_PARITY_EN
      check("out_parity", 64'(sif.out_parity), 64'(^exp_q[0]));
`endif
    end else begin
      check("out_last_idle", 64'(sif.out_last), 64'd0);
`ifdef STREAMER_PARITY_EN
      check("out_parity_idle", 64'(sif.out_parity), 64'd0);
`endif
    end
    if (m_reset_seen) begin
      check("rst_out_index", 64'(sif.out_index), 64'd0);
      check("rst_out_data", sif.out_data, 64'd0);
    end
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic lane_pattern();
    for (int k = 0; k < NW; k++) enc_data[k*WW +: WW] = 64'h0101010101010101 * 64'(k);
  endtask

  task automatic random_data();
    for (int k = 0; k < NW; k++) enc_data[k*WW +: WW] = {$urandom, $urandom};
  endtask

  initial begin
    sif.out_ready = 1'b0;
    // Reset state
    ticks(3);
    rst = 1'b1;
    ticks(2);

    // Full-rate stream of the lane pattern
    lane_pattern();
    sif.out_ready = 1'b1;
    enc_done = 1'b1;
    ticks(30);
    enc_done = 1'b0;
    ticks(2);

    // Back-pressure pattern 1,0,0 repeating
    enc_done = 1'b1;
    for (int i = 0; i < 90; i++) begin
      sif.out_ready = (i % 3 == 0);
      tick();
    end
    enc_done = 1'b0;
    sif.out_ready = 1'b1;
    ticks(3);

    // Second done edge mid-stream must be ignored and flag overrun
    random_data();
    enc_done = 1'b1;
    ticks(10);
    enc_done = 1'b0;
    tick();
    random_data();
    enc_done = 1'b1;
    ticks(20);
    enc_done = 1'b0;
    ticks(2);

    // Reset mid-stream at word 7
    random_data();
    enc_done = 1'b1;
    ticks(8);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    enc_done = 1'b0;
    ticks(3);

    // Level held high long after stream: no re-trigger; then fall and rise again
    random_data();
    enc_done = 1'b1;
    ticks(126);
    enc_done = 1'b0;
    tick();
    random_data();
    enc_data[0 +: WW]  = 64'h1;
    enc_data[WW +: WW] = 64'h3;
    enc_done = 1'b1;
    ticks(30);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      sif.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) enc_done = ~enc_done;
      if ($urandom_range(0, 7) == 0) random_data();
      rst = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
